// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on request and result sides.
// Define ALU_MULDIV_EN to build the iterative MUL/DIVU/REMU unit; without it those codes return 0.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUCtrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             ZERO,
    output logic [1:0]       dbg_state
);

    // Request taken on in_valid && in_ready, result taken on out_valid && out_ready;
    // in_ready (IDLE) and out_valid (DONE) are never high together.
    localparam int SH = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             zero_q, zero_d;
    logic             accept;

    function automatic logic [WIDTH-1:0] simple_op(input logic [3:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        r = '0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0011: r = a ^ b;
            4'b0100: r = a << b[SH-1:0];
            4'b0101: r = a >> b[SH-1:0];
            4'b0110: r = a - b;
            4'b0111: r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign accept    = in_valid && in_ready;
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Y         = y_q;
    assign ZERO      = zero_q;
    assign dbg_state = state_q;

`ifdef ALU_MULDIV_EN
    localparam logic [SH-1:0] LAST_ITER = SH'(WIDTH - 1);

    // MUL: a_q = shifted multiplicand, b_q = shifted multiplier, acc_q = partial sum.
    // DIVU/REMU: a_q = dividend shifting into quotient, b_q = divisor, acc_q = remainder.
    logic [SH-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d, a_q, a_d, b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic             is_muldiv;
    logic [WIDTH-1:0] mul_acc, rem_next, quo_next, iter_res;
    logic [WIDTH:0]   div_r, div_diff;
    logic             div_fits;

    assign is_muldiv = ALUCtrl inside {4'b1000, 4'b1001, 4'b1010};
    assign mul_acc   = b_q[0] ? (acc_q + a_q) : acc_q;
    assign div_r     = {acc_q, a_q[WIDTH-1]};
    assign div_diff  = div_r - {1'b0, b_q};
    assign div_fits  = !div_diff[WIDTH];
    assign rem_next  = div_fits ? div_diff[WIDTH-1:0] : div_r[WIDTH-1:0];
    assign quo_next  = {a_q[WIDTH-2:0], div_fits};
    assign iter_res  = (op_q == 4'b1000) ? mul_acc :
                       (op_q == 4'b1001) ? quo_next : rem_next;
`endif

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        zero_d  = zero_q;
`ifdef ALU_MULDIV_EN
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef ALU_MULDIV_EN
                    if (is_muldiv) begin
                        state_d = BUSY;
                        op_d    = ALUCtrl;
                        cnt_d   = '0;
                        acc_d   = '0;
                        a_d     = A;
                        b_d     = B;
                    end else begin
                        state_d = DONE;
                        y_d     = simple_op(ALUCtrl, A, B);
                        zero_d  = (simple_op(ALUCtrl, A, B) == '0);
                    end
`else
                    state_d = DONE;
                    y_d     = simple_op(ALUCtrl, A, B);
                    zero_d  = (simple_op(ALUCtrl, A, B) == '0);
`endif
                end
            end
`ifdef ALU_MULDIV_EN
            BUSY: begin
                if (op_q == 4'b1000) begin
                    acc_d = mul_acc;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                end else begin
                    acc_d = rem_next;
                    a_d   = quo_next;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    y_d     = iter_res;
                    zero_d  = (iter_res == '0);
                end
            end
`endif
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            y_q     <= '0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            zero_q  <= zero_d;
        end
    end

`ifdef ALU_MULDIV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            acc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            a_q   <= a_d;
            b_q   <= b_d;
            op_q  <= op_d;
        end
    end
`endif

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH = 32): transaction-level reference model checked every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_alu_mc;

    localparam int W = 32;
`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif
    localparam int MD_LAT = MD ? 33 : 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, zero;
    logic [W-1:0] a, b, y;
    logic [3:0]   alu_ctrl;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .ALUCtrl   (alu_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (y),
        .ZERO      (zero),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] model_res(input logic [3:0] op, input logic [W-1:0] x,
                                               input logic [W-1:0] z);
        case (op)
            4'd0:  return x & z;
            4'd1:  return x | z;
            4'd2:  return x + z;
            4'd3:  return x ^ z;
            4'd4:  return x << (z % W);
            4'd5:  return x >> (z % W);
            4'd6:  return x - z;
            4'd7:  return ($signed(x) < $signed(z)) ? 32'd1 : 32'd0;
            4'd8:  return MD ? x * z : 32'd0;
            4'd9:  return !MD ? 32'd0 : (z == 0) ? 32'hFFFF_FFFF : x / z;
            4'd10: return !MD ? 32'd0 : (z == 0) ? x : x % z;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] op);
        return (op >= 4'd8 && op <= 4'd10) ? MD_LAT : 1;
    endfunction

    logic         m_idle, m_valid;
    logic [W-1:0] m_y;
    int           m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle  <= 1'b1;
            m_valid <= 1'b0;
            m_cnt   <= 0;
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid <= 1'b0;
                m_idle  <= 1'b1;
            end
        end else if (m_idle) begin
            if (in_valid) begin
                m_idle <= 1'b0;
                m_y    <= model_res(alu_ctrl, a, b);
                if (model_lat(alu_ctrl) == 1) m_valid <= 1'b1;
                else m_cnt <= model_lat(alu_ctrl) - 1;
            end
        end else begin
            if (m_cnt == 1) m_valid <= 1'b1;
            m_cnt <= m_cnt - 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_in_ready", {31'd0, in_ready}, {31'd0, m_idle});
            check("cyc_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            if (m_valid) begin
                check("cyc_y", y, m_y);
                check("cyc_zero", {31'd0, zero}, {31'd0, (m_y == 0)});
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_op(input string name, input logic [3:0] op, input logic [W-1:0] xa,
                         input logic [W-1:0] xb, input logic [W-1:0] exp_y, input int exp_lat,
                         input int hold);
        int lat;
        @(negedge clk);
        out_ready = (hold == 0);
        alu_ctrl  = op;
        a         = xa;
        b         = xb;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        alu_ctrl = 4'($urandom_range(0, 15));
        lat      = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_y"}, y, exp_y);
        check({name, "_zero"}, {31'd0, zero}, {31'd0, (exp_y == 0)});
        for (int i = 0; i < hold; i++) begin
            in_valid = (i == 2);
            alu_ctrl = 4'd2;
            a        = 32'd1;
            b        = 32'd1;
            @(negedge clk);
            check({name, "_hold_y"}, y, exp_y);
            check({name, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check({name, "_idle_after"}, {31'd0, in_ready}, 32'd1);
        check({name, "_valid_after"}, {31'd0, out_valid}, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        alu_ctrl  = '0;
        #3 rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_y", y, 32'd0);
        check("reset_zero", {31'd0, zero}, 32'd1);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        do_op("sub_3_3",   4'b0110, 32'd3,          32'd3,          32'd0,          1, 0);
        do_op("add_wrap",  4'b0010, 32'hFFFF_FFFF,  32'd1,          32'd0,          1, 0);
        do_op("slt_neg",   4'b0111, 32'hFFFF_FFFF,  32'd1,          32'd1,          1, 0);
        do_op("slt_pos",   4'b0111, 32'd1,          32'hFFFF_FFFF,  32'd0,          1, 0);
        do_op("sll_mask",  4'b0100, 32'd1,          32'h21,         32'd2,          1, 0);
        do_op("srl_31",    4'b0101, 32'h8000_0000,  32'h1F,         32'd1,          1, 0);
        do_op("and",       4'b0000, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1, 0);
        do_op("or",        4'b0001, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_FFF0,  1, 0);
        do_op("xor",       4'b0011, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_0FF0,  1, 0);
        do_op("mul_wrap",  4'b1000, 32'h0001_0000,  32'h0001_0001,  MD ? 32'h0001_0000 : 32'd0, MD_LAT, 0);
        do_op("mul_3_4",   4'b1000, 32'd3,          32'd4,          MD ? 32'd12 : 32'd0, MD_LAT, 0);
        do_op("divu_100_7", 4'b1001, 32'd100,       32'd7,          MD ? 32'd14 : 32'd0, MD_LAT, 0);
        do_op("remu_100_7", 4'b1010, 32'd100,       32'd7,          MD ? 32'd2 : 32'd0,  MD_LAT, 0);
        do_op("divu_by0",  4'b1001, 32'd9,          32'd0,          MD ? 32'hFFFF_FFFF : 32'd0, MD_LAT, 0);
        do_op("remu_by0",  4'b1010, 32'd9,          32'd0,          MD ? 32'd9 : 32'd0,  MD_LAT, 0);
        do_op("unknown_f", 4'b1111, 32'd123,        32'd456,        32'd0,          1, 0);
        do_op("backpress", 4'b0010, 32'd20,         32'd22,         32'd42,         1, 5);

        // Reset in the middle of a multiply, then a fresh ADD.
        @(negedge clk);
        alu_ctrl = 4'b1000;
        a        = 32'h0001_0000;
        b        = 32'h0001_0001;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_y", y, 32'd0);
        check("midrst_zero", {31'd0, zero}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("add_after_rst", 4'b0010, 32'd5, 32'd7, 32'd12, 1, 0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
